// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: shared constants and helpers for the APB timer completer.
//   Register word offsets (PADDR[4:2]), CTRL/STATUS bit positions, field
//   widths and a byte-lane merge helper used for strobed writes.
package apb_timer_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CTRL_W = 8;
   localparam int unsigned WS_W   = 4;
   localparam int unsigned SEL_W  = 3;

   // Register offsets expressed as word index (byte offset >> 2)
   localparam logic [SEL_W-1:0] OFF_CTRL    = 3'd0;
   localparam logic [SEL_W-1:0] OFF_LOAD    = 3'd1;
   localparam logic [SEL_W-1:0] OFF_VALUE   = 3'd2;
   localparam logic [SEL_W-1:0] OFF_STATUS  = 3'd3;
   localparam logic [SEL_W-1:0] OFF_SCRATCH = 3'd4;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_RELOAD = 1;
   localparam int unsigned CTRL_IRQEN  = 2;
   localparam int unsigned CTRL_WS_LSB = 4;
   localparam int unsigned CTRL_WS_MSB = 7;

   localparam int unsigned STATUS_EXP = 0;

   // Implemented CTRL bits; bit 3 is reserved and always reads 0
   localparam logic [CTRL_W-1:0] CTRL_MASK = 8'hF7;

   // Replace the byte lanes of old_word whose strobe bit is set
   function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] wdata,
                                                     input logic [3:0]        strb);
      logic [DATA_W-1:0] r;
      r = old_word;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/apb_timer_core.sv
// apb_timer_core: 32-bit down counter with reload, expiry flag and EN auto-clear.
//   clk, rst_n  : clock, async active-low reset
//   tick        : APB clock enable; all state moves only when high
//   ctrl        : current CTRL register (EN, RELOAD used here)
//   load        : current LOAD register (reload source)
//   load_wr     : LOAD write commits this tick; load_data goes to VALUE
//   exp_clr     : STATUS W1C of EXP this tick
//   en_wr       : CTRL write commits this tick (its EN beats auto-clear)
//   value, exp  : counter and expiry flag
//   en_clr      : request to clear CTRL.EN (one-shot expiry)
module apb_timer_core
   import apb_timer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic [CTRL_W-1:0] ctrl,
   input  logic [DATA_W-1:0] load,
   input  logic              load_wr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              exp_clr,
   input  logic              en_wr,
   output logic [DATA_W-1:0] value,
   output logic              exp,
   output logic              en_clr
);

   logic step;
   logic expire;

   assign step   = tick & ctrl[CTRL_EN];
   assign expire = step & (value == '0);
   assign en_clr = expire & ~ctrl[CTRL_RELOAD] & ~en_wr;

   // A LOAD write overrides the counter step; expiry set beats W1C
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
         exp   <= 1'b0;
      end else begin
         if (load_wr) begin
            value <= load_data;
         end else if (step) begin
            if (expire) begin
               if (ctrl[CTRL_RELOAD]) value <= load;
            end else begin
               value <= value - DATA_W'(1);
            end
         end
         if (expire)       exp <= 1'b1;
         else if (exp_clr) exp <= 1'b0;
      end
   end

endmodule

// File: rtl/apb_timer_completer.sv
// apb_timer_completer: APB3 completer with register bank and down-counting timer.
//   HCLK, HRESETn : clock, async active-low reset
//   PCLKEN        : APB tick; sampling and all state updates only when high
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA : APB request
//   PRDATA/PREADY/PSLVERR            : APB response (PREADY from wait counter)
//   IRQ           : level interrupt, EXP & IRQEN
// Optional build macro APB4_EN adds PSTRB (byte-lane writes) and PPROT
// (unprivileged access to CTRL/LOAD is rejected).
module apb_timer_completer
   import apb_timer_pkg::*;
#(
   parameter int unsigned ADDRWIDTH = 16,
   parameter int unsigned DATAWIDTH = 32
)(
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 PCLKEN,
   input  logic                 PSEL,
   input  logic                 PENABLE,
   input  logic [ADDRWIDTH-1:0] PADDR,
   input  logic                 PWRITE,
   input  logic [DATAWIDTH-1:0] PWDATA,
`ifdef APB4_EN
   input  logic [3:0]           PSTRB,
   input  logic [2:0]           PPROT,
`endif
   output logic [DATAWIDTH-1:0] PRDATA,
   output logic                 PREADY,
   output logic                 PSLVERR,
   output logic                 IRQ
);

   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] load;
   logic [DATA_W-1:0] scratch;
   logic [WS_W-1:0]   wcnt;
   logic [DATA_W-1:0] value;
   logic              exp;
   logic              en_clr;

   logic [SEL_W-1:0]  sel;
   logic [3:0]        strb;
   logic              priv_err;
   logic              err;
   logic              access;
   logic              commit;
   logic              ctrl_wr, load_wr, status_wr, scratch_wr, exp_clr;
   logic [CTRL_W-1:0] ctrl_new;
   logic [DATA_W-1:0] load_new;
   logic [DATA_W-1:0] rdata;
   logic              unused;

   assign sel = PADDR[4:2];

`ifdef APB4_EN
   assign strb     = PSTRB;
   assign priv_err = ~PPROT[0] & ((sel == OFF_CTRL) | (sel == OFF_LOAD));
   assign unused   = ^{PADDR[ADDRWIDTH-1:5], PADDR[1:0], PPROT[2:1]};
`else
   assign strb     = 4'hF;
   assign priv_err = 1'b0;
   assign unused   = ^{PADDR[ADDRWIDTH-1:5], PADDR[1:0]};
`endif

   // Unmapped offsets, writes to read-only VALUE, and privilege violations
   assign err = (sel > OFF_SCRATCH) | (PWRITE & (sel == OFF_VALUE)) | priv_err;

   assign PREADY = (wcnt == '0);
   assign access = PSEL & PENABLE & PREADY;
   assign commit = PCLKEN & access & PWRITE & ~err;

   assign ctrl_wr    = commit & (sel == OFF_CTRL);
   assign load_wr    = commit & (sel == OFF_LOAD);
   assign status_wr  = commit & (sel == OFF_STATUS);
   assign scratch_wr = commit & (sel == OFF_SCRATCH);
   assign exp_clr    = status_wr & strb[0] & PWDATA[STATUS_EXP];

   // CTRL lives entirely in byte lane 0
   assign ctrl_new = (strb[0] ? PWDATA[CTRL_W-1:0] : ctrl) & CTRL_MASK;
   assign load_new = merge_lanes(load, PWDATA, strb);

   // Wait counter, CTRL/LOAD/SCRATCH registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wcnt    <= '0;
         ctrl    <= '0;
         load    <= '0;
         scratch <= '0;
      end else if (PCLKEN) begin
         if (PSEL && !PENABLE)                 wcnt <= ctrl[CTRL_WS_MSB:CTRL_WS_LSB];
         else if (PSEL && PENABLE && wcnt != '0) wcnt <= wcnt - WS_W'(1);
         if (ctrl_wr)     ctrl <= ctrl_new;
         else if (en_clr) ctrl[CTRL_EN] <= 1'b0;
         if (load_wr)     load <= load_new;
         if (scratch_wr)  scratch <= merge_lanes(scratch, PWDATA, strb);
      end
   end

   apb_timer_core u_core (
      .clk       (HCLK),
      .rst_n     (HRESETn),
      .tick      (PCLKEN),
      .ctrl      (ctrl),
      .load      (load),
      .load_wr   (load_wr),
      .load_data (load_new),
      .exp_clr   (exp_clr),
      .en_wr     (ctrl_wr),
      .value     (value),
      .exp       (exp),
      .en_clr    (en_clr)
   );

   // Read mux
   always_comb begin
      rdata = '0;
      case (sel)
         OFF_CTRL:    rdata = DATA_W'(ctrl);
         OFF_LOAD:    rdata = load;
         OFF_VALUE:   rdata = value;
         OFF_STATUS:  rdata = DATA_W'(exp);
         OFF_SCRATCH: rdata = scratch;
         default:     rdata = '0;
      endcase
   end

   assign PRDATA  = (access & ~PWRITE & ~err) ? rdata : '0;
   assign PSLVERR = access & err;
   assign IRQ     = exp & ctrl[CTRL_IRQEN];

endmodule

// File: tb/tb_apb_timer_completer.sv
// tb_apb_timer_completer: self-checking bench for apb_timer_completer.
//   Table of single transfers, hand-written timer/wait-state corner sequences,
//   then randomized transfers checked against a register-level model.
//   Build with APB4_EN to exercise PSTRB/PPROT.
module tb_apb_timer_completer;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b1;
   logic        PCLKEN = 1'b1;
   logic        PSEL = 1'b0;
   logic        PENABLE = 1'b0;
   logic [15:0] PADDR = '0;
   logic        PWRITE = 1'b0;
   logic [31:0] PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic        IRQ;
   logic [3:0]  strb_v = 4'hF;
   logic [2:0]  prot_v = 3'b001;

   apb_timer_completer dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .PCLKEN  (PCLKEN),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PADDR   (PADDR),
      .PWRITE  (PWRITE),
      .PWDATA  (PWDATA),
`ifdef APB4_EN
      .PSTRB   (strb_v),
      .PPROT   (prot_v),
`endif
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR),
      .IRQ     (IRQ)
   );

   always #5 HCLK = ~HCLK;

   int checks = 0;
   int errors = 0;
   int div = 1;
   int phase = 0;

   // Reference model: register contents as the programmer sees them
   bit          m_en, m_reload, m_irqen, m_exp;
   logic [3:0]  m_ws;
   logic [31:0] m_load, m_value, m_scratch;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      bit          er;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_en = 0; m_reload = 0; m_irqen = 0; m_exp = 0;
      m_ws = '0; m_load = '0; m_value = '0; m_scratch = '0;
   endtask

   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
      return r;
   endfunction

   function automatic bit model_err(input bit w, input logic [2:0] s);
      return (s > 3'd4) || (w && s == 3'd2) || (!prot_v[0] && (s == 3'd0 || s == 3'd1));
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] s);
      case (s)
         3'd0: return {24'b0, m_ws, 1'b0, m_irqen, m_reload, m_en};
         3'd1: return m_load;
         3'd2: return m_value;
         3'd3: return {31'b0, m_exp};
         3'd4: return m_scratch;
         default: return 32'h0;
      endcase
   endfunction

   // One APB tick of the model; commit=1 when this tick completes a transfer
   task automatic model_tick(input bit commit);
      bit          expire;
      logic [2:0]  s;
      logic [31:0] cm;
      s = PADDR[4:2];
      expire = 0;
      if (m_en) begin
         if (m_value != 0) m_value = m_value - 1;
         else begin
            expire = 1;
            m_exp = 1;
            if (m_reload) m_value = m_load;
            else m_en = 0;
         end
      end
      if (commit && PWRITE && !model_err(PWRITE, s)) begin
         case (s)
            3'd0: begin
               cm = mrg(model_read(3'd0), PWDATA, strb_v);
               m_en = cm[0]; m_reload = cm[1]; m_irqen = cm[2]; m_ws = cm[7:4];
            end
            3'd1: begin m_load = mrg(m_load, PWDATA, strb_v); m_value = m_load; end
            3'd3: if (strb_v[0] && PWDATA[0] && !expire) m_exp = 0;
            3'd4: m_scratch = mrg(m_scratch, PWDATA, strb_v);
            default: ;
         endcase
      end
   endtask

   // One HCLK: advance model on ticks, then set PCLKEN for the next cycle
   task automatic cyc(input bit commit);
      if (PCLKEN) model_tick(commit);
      @(posedge HCLK);
      #1;
      phase = (phase + 1) % div;
      PCLKEN = (phase == 0);
      chk("irq", 32'(IRQ), 32'(m_exp & m_irqen));
   endtask

   task automatic set_div(input int d);
      div = d; phase = 0; PCLKEN = 1'b1;
   endtask

   // Full transfer; returns read data, error, HCLKs with PREADY low, ticks used
   task automatic apb(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output bit er, output int lowh, output int ticks);
      int ws_exp, lowt;
      bit done;
      logic [31:0] exp_rd;
      bit exp_er;
      PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wd;
      ticks = 0; lowh = 0; lowt = 0; done = 0; rd = '0; er = 0; ws_exp = 0;
      for (int i = 0; i < 8 && !done; i++) begin
         if (PCLKEN) begin done = 1; ws_exp = int'(m_ws); ticks++; end
         cyc(0);
      end
      PENABLE = 1;
      done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         #1;
         if (PCLKEN) ticks++;
         if (PREADY && PCLKEN) begin
            exp_er = model_err(wr, addr[4:2]);
            exp_rd = (wr || exp_er) ? 32'h0 : model_read(addr[4:2]);
            rd = PRDATA; er = PSLVERR;
            chk("prdata_model", rd, exp_rd);
            chk("pslverr_model", 32'(er), 32'(exp_er));
            done = 1;
            cyc(1);
         end else begin
            if (!PREADY) begin lowh++; if (PCLKEN) lowt++; end
            cyc(0);
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL apb_timeout addr=%h actual=no_completion expected=completion", addr);
      end
      chk("wait_ticks", 32'(lowt), 32'(ws_exp));
      PSEL = 0; PENABLE = 0; PWRITE = 0;
   endtask

   task automatic w(input logic [15:0] a, input logic [31:0] d);
      logic [31:0] rd; bit er; int lh, tk;
      apb(1, a, d, rd, er, lh, tk);
   endtask

   task automatic r(input logic [15:0] a, output logic [31:0] rd);
      bit er; int lh, tk;
      apb(0, a, 32'h0, rd, er, lh, tk);
   endtask

   initial begin
      vec_t        tv[16];
      logic [31:0] rd, d;
      logic [15:0] a;
      bit          er, wr;
      int          lowh, tk;

      tv[0]  = '{0, 16'h0000, 32'h0,         32'h0,         0};
      tv[1]  = '{1, 16'h0010, 32'hA5A5_5A5A, 32'h0,         0};
      tv[2]  = '{0, 16'h0010, 32'h0,         32'hA5A5_5A5A, 0};
      tv[3]  = '{0, 16'h0018, 32'h0,         32'h0,         1};
      tv[4]  = '{0, 16'h0014, 32'h0,         32'h0,         1};
      tv[5]  = '{1, 16'h001C, 32'hFFFF_FFFF, 32'h0,         1};
      tv[6]  = '{1, 16'h0004, 32'h0000_1234, 32'h0,         0};
      tv[7]  = '{1, 16'h0008, 32'h0000_DEAD, 32'h0,         1};
      tv[8]  = '{0, 16'h0008, 32'h0,         32'h0000_1234, 0};
      tv[9]  = '{0, 16'h0004, 32'h0,         32'h0000_1234, 0};
      tv[10] = '{1, 16'h0013, 32'h0000_0003, 32'h0,         0};
      tv[11] = '{0, 16'h0011, 32'h0,         32'h0000_0003, 0};
      tv[12] = '{1, 16'h0000, 32'hFFFF_FF08, 32'h0,         0};
      tv[13] = '{0, 16'h0000, 32'h0,         32'h0,         0};
      tv[14] = '{0, 16'h000C, 32'h0,         32'h0,         0};
      tv[15] = '{1, 16'h000C, 32'hFFFF_FFFF, 32'h0,         0};

      model_reset();
      #2 HRESETn = 0;
      repeat (3) @(posedge HCLK);
      #1 HRESETn = 1;
      chk("rst_pready", 32'(PREADY), 32'd1);
      chk("rst_pslverr", 32'(PSLVERR), 32'd0);
      chk("rst_prdata", PRDATA, 32'd0);
      chk("rst_irq", 32'(IRQ), 32'd0);
      @(posedge HCLK);
      #1;

      // Table-driven single transfers, WS=0 throughout
      for (int i = 0; i < 16; i++) begin
         apb(tv[i].wr, tv[i].addr, tv[i].wd, rd, er, lowh, tk);
         chk($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(tv[i].er));
         chk($sformatf("vec%0d_ticks", i), 32'(tk), 32'd2);
      end

      // Wait states: WS change applies to the next transfer only
      apb(1, 16'h0000, 32'h30, rd, er, lowh, tk);
      chk("ws_write_ticks", 32'(tk), 32'd2);
      apb(0, 16'h0010, 32'h0, rd, er, lowh, tk);
      chk("ws3_low_hclk", 32'(lowh), 32'd3);
      chk("ws3_ticks", 32'(tk), 32'd5);
      set_div(2);
      apb(0, 16'h0010, 32'h0, rd, er, lowh, tk);
      chk("ws3_div2_low_hclk", 32'(lowh), 32'd6);
      chk("ws3_div2_rdata", rd, 32'h3);
      set_div(1);

      // PSEL dropped mid-wait: no commit, wcnt reloaded on next setup
      PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 16'h0010; PWDATA = 32'h1111_2222;
      cyc(0);
      PENABLE = 1;
      cyc(0);
      PSEL = 0; PENABLE = 0; PWRITE = 0;
      cyc(0); cyc(0);
      apb(0, 16'h0010, 32'h0, rd, er, lowh, tk);
      chk("drop_no_commit", rd, 32'h3);
      chk("drop_reload_low", 32'(lowh), 32'd3);
      apb(1, 16'h0000, 32'h0, rd, er, lowh, tk);
      chk("ws_clear_ticks", 32'(tk), 32'd5);

      // Reloading timer: IRQ after 4 ticks, VALUE reloads
      w(16'h0004, 32'd3);
      w(16'h0000, 32'h7);
      for (int k = 1; k <= 4; k++) begin
         cyc(0);
         chk($sformatf("irq_tick%0d", k), 32'(IRQ), (k == 4) ? 32'd1 : 32'd0);
      end
      r(16'h0008, rd);
      chk("value_reloaded", rd, 32'd2);
      // W1C on the same tick as expiry: set wins
      for (int i = 0; i < 20 && m_value != 1; i++) cyc(0);
      w(16'h000C, 32'h1);
      chk("w1c_vs_expire_irq", 32'(IRQ), 32'd1);
      r(16'h000C, rd);
      chk("w1c_vs_expire_exp", rd, 32'd1);
      for (int i = 0; i < 20 && m_value != 3; i++) cyc(0);
      w(16'h000C, 32'h1);
      chk("w1c_irq_drop", 32'(IRQ), 32'd0);
      // LOAD write beats timer step
      w(16'h0004, 32'd100);
      r(16'h0008, rd);
      chk("load_wins_value", rd, 32'd99);
      w(16'h0000, 32'h0);
      w(16'h000C, 32'h1);

      // One-shot: EN auto-clears at expiry
      w(16'h0004, 32'd2);
      w(16'h0000, 32'h5);
      cyc(0); cyc(0);
      r(16'h0000, rd);
      chk("oneshot_ctrl", rd, 32'h4);
      r(16'h0008, rd);
      chk("oneshot_value", rd, 32'h0);
      chk("oneshot_irq", 32'(IRQ), 32'd1);
      w(16'h000C, 32'h1);
      // CTRL write on the auto-clear tick: written EN wins
      w(16'h0004, 32'd2);
      w(16'h0000, 32'h5);
      cyc(0);
      w(16'h0000, 32'h7);
      r(16'h0000, rd);
      chk("ctrl_vs_autoclr", rd, 32'h7);
      w(16'h0000, 32'h0);
      w(16'h000C, 32'h1);

`ifdef APB4_EN
      w(16'h0010, 32'h0);
      strb_v = 4'b0010;
      w(16'h0010, 32'hFFFF_FFFF);
      strb_v = 4'hF;
      r(16'h0010, rd);
      chk("apb4_strb", rd, 32'h0000_FF00);
      prot_v = 3'b000;
      apb(1, 16'h0000, 32'h1, rd, er, lowh, tk);
      chk("apb4_prot_err", 32'(er), 32'd1);
      prot_v = 3'b001;
      r(16'h0000, rd);
      chk("apb4_prot_ctrl", rd, 32'h0);
`endif

      // Randomized transfers against the model
      for (int n = 0; n < 250; n++) begin
         set_div(int'($urandom_range(1, 3)));
         wr = 1'($urandom_range(0, 1));
         a  = 16'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
         d  = $urandom;
         if (wr && a[4:2] == 3'd0) d[7:4] = 4'($urandom_range(0, 3));
         if (wr && a[4:2] == 3'd1) d = 32'($urandom_range(0, 20));
         apb(wr, a, d, rd, er, lowh, tk);
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) cyc(0);
      end
      set_div(1);

      // Asynchronous reset in the middle of a waited transfer
      w(16'h0000, 32'h50);
      PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 16'h0010;
      cyc(0);
      PENABLE = 1;
      #1;
      chk("midxfer_wait", 32'(PREADY), 32'd0);
      HRESETn = 0;
      #1;
      chk("midxfer_rst_pready", 32'(PREADY), 32'd1);
      chk("midxfer_rst_irq", 32'(IRQ), 32'd0);
      chk("midxfer_rst_prdata", PRDATA, 32'd0);
      model_reset();
      PSEL = 0; PENABLE = 0;
      @(posedge HCLK);
      #1;
      HRESETn = 1;
      set_div(1);
      r(16'h0000, rd);
      chk("post_rst_ctrl", rd, 32'h0);
      r(16'h0010, rd);
      chk("post_rst_scratch", rd, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
